// File: rtl/gpr_write_arbiter_pkg.sv
// Shared sizes and state encoding for the gpr write-port arbiter.
package gpr_pkg;

    localparam int GPR_ADDR_W = 5;
    localparam int GPR_DATA_W = 32;
    localparam int GPR_DEPTH  = 32;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } gpr_state_t;

endpackage

// File: rtl/gpr_write_arbiter_rr_arbiter.sv
// Round-robin priority picker: searches from ptr+1 upward (mod N) and grants
// the first active request. Purely combinational.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 any_grant
);

    localparam int IW = $clog2(N);

    // Walk the requesters in rotated order; the first hit wins.
    always_comb begin
        logic [IW-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!any_grant && req[idx]) begin
                any_grant      = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/gpr_write_arbiter.sv
// Owns gpr write port C: zeroes the register file after reset or on command,
// then shares the port round-robin between NUM_REQ valid/ready requesters.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  ST_CLEAR | walking addresses 0..DEPTH-1 writing zero; no requests taken
//  ST_RUN   | normal operation; one round-robin grant per cycle
module gpr_write_arbiter
    import gpr_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = GPR_ADDR_W,
    parameter int DATA_W         = GPR_DATA_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_req,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         gpr_write_enable,
    output logic [ADDR_W-1:0]            gpr_addrC,
    output logic [DATA_W-1:0]            gpr_data_in_C,
    output logic                         init_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int IDX_W = $clog2(NUM_REQ);

    gpr_state_t         state, state_nxt;
    logic [ADDR_W-1:0]  clr_cnt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    // Requests only reach the arbiter in RUN, out of reset, and when no clear
    // is being launched; this alone keeps ready/grant_id at zero otherwise.
    assign arb_req = (rst_n && state == ST_RUN && !clear_req) ? req_valid : '0;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req       (arb_req),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_grant (arb_any)
    );

    assign req_ready = arb_grant;
    assign grant_id  = arb_idx;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
        else
            state <= state_nxt;
    end

    // Next-state: leave CLEAR after the last address, re-enter on clear_req.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (clr_cnt == ADDR_W'(DEPTH - 1)) state_nxt = ST_RUN;
            ST_RUN:   if (clear_req)                     state_nxt = ST_CLEAR;
            default:  state_nxt = state;
        endcase
    end

    // Clear counter, round-robin pointer and registered port-C drive.
    // init_done follows the state by one cycle so it rises together with the
    // first port-C cycle that is no longer part of the clear sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_cnt          <= '0;
            rr_ptr           <= IDX_W'(NUM_REQ - 1);
            gpr_write_enable <= 1'b0;
            gpr_addrC        <= '0;
            gpr_data_in_C    <= '0;
            init_done        <= 1'b0;
        end else begin
            init_done <= (state == ST_RUN);
            if (state == ST_CLEAR) begin
                gpr_write_enable <= 1'b1;
                gpr_addrC        <= clr_cnt;
                gpr_data_in_C    <= '0;
                clr_cnt          <= clr_cnt + 1'b1;
            end else begin
                clr_cnt <= '0;
                if (arb_any) begin
                    gpr_write_enable <= 1'b1;
                    gpr_addrC        <= req_addr[arb_idx*ADDR_W +: ADDR_W];
                    gpr_data_in_C    <= req_data[arb_idx*DATA_W +: DATA_W];
                    rr_ptr           <= arb_idx;
                end else begin
                    gpr_write_enable <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Directed bench for gpr_write_arbiter with a behavioural 32x32 gpr behind it.
module tb_gpr_write_arbiter;
    import gpr_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        clear_req;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr;
    logic [NUM_REQ*DATA_W-1:0]   req_data;
    logic [NUM_REQ-1:0]          req_ready;
    logic [1:0]                  grant_id;
    logic                        gpr_write_enable;
    logic [ADDR_W-1:0]           gpr_addrC;
    logic [DATA_W-1:0]           gpr_data_in_C;
    logic                        init_done;

    logic [DATA_W-1:0] mem [32];
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] data_out_A, data_out_B;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gpr_write_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .clear_req        (clear_req),
        .req_valid        (req_valid),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .grant_id         (grant_id),
        .gpr_write_enable (gpr_write_enable),
        .gpr_addrC        (gpr_addrC),
        .gpr_data_in_C    (gpr_data_in_C),
        .init_done        (init_done)
    );

    // Register file model: port C write, two combinational read ports.
    always @(posedge clk) begin
        if (gpr_write_enable) mem[gpr_addrC] <= gpr_data_in_C;
    end
    assign data_out_A = mem[addr_a];
    assign data_out_B = mem[addr_b];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        clear_req = 1'b0;
        req_valid = 4'hF;
        req_addr  = '0;
        req_data  = '0;
        addr_a    = '0;
        addr_b    = '0;

        // Reset: outputs zero, ready forced low even with all requests valid.
        repeat (3) tick();
        chk("rst_we", 32'(gpr_write_enable), 32'd0);
        chk("rst_addr", 32'(gpr_addrC), 32'd0);
        chk("rst_data", gpr_data_in_C, 32'd0);
        chk("rst_init", 32'(init_done), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);

        // Power-on clear sweep: 32 writes of zero, addresses 0..31.
        rst_n     = 1'b1;
        req_valid = '0;
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("clr0_we", 32'(gpr_write_enable), 32'd1);
            chk("clr0_addr", 32'(gpr_addrC), 32'(i));
            chk("clr0_data", gpr_data_in_C, 32'd0);
            chk("clr0_init", 32'(init_done), 32'd0);
        end
        tick();
        chk("clr0_done_init", 32'(init_done), 32'd1);
        chk("clr0_done_we", 32'(gpr_write_enable), 32'd0);
        addr_a = 5'd5;
        addr_b = 5'd31;
        #1;
        chk("clr0_rd5", data_out_A, 32'd0);
        chk("clr0_rd31", data_out_B, 32'd0);

        // Single requester 2.
        set_req(2, 5'd5, 32'hAAAAAAAA);
        req_valid = 4'b0100;
        #1;
        chk("r2_ready", 32'(req_ready), 32'h4);
        chk("r2_gid", 32'(grant_id), 32'd2);
        tick();
        req_valid = '0;
        chk("r2_we", 32'(gpr_write_enable), 32'd1);
        chk("r2_addr", 32'(gpr_addrC), 32'd5);
        chk("r2_data", gpr_data_in_C, 32'hAAAAAAAA);
        addr_b = 5'd5;
        tick();
        chk("r2_idle_we", 32'(gpr_write_enable), 32'd0);
        chk("r2_rdB", data_out_B, 32'hAAAAAAAA);

        // Requester 3 alone, so the pointer sits at 3 before the full sweep.
        set_req(3, 5'd7, 32'h00003333);
        req_valid = 4'b1000;
        #1;
        chk("r3_ready", 32'(req_ready), 32'h8);
        chk("r3_gid", 32'(grant_id), 32'd3);
        tick();
        req_valid = '0;
        chk("r3_addr", 32'(gpr_addrC), 32'd7);

        // All four valid for 8 cycles: strict rotation 0,1,2,3,0,1,2,3.
        for (int k = 0; k < 4; k++) set_req(k, 5'(k + 1), 32'h100 + 32'(k));
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
            chk("rr_gid", 32'(grant_id), 32'(k % 4));
            tick();
            chk("rr_we", 32'(gpr_write_enable), 32'd1);
            chk("rr_addr", 32'(gpr_addrC), 32'((k % 4) + 1));
            chk("rr_data", gpr_data_in_C, 32'h100 + 32'(k % 4));
        end
        req_valid = '0;
        tick();
        chk("rr_idle_we", 32'(gpr_write_enable), 32'd0);

        // clear_req beats a simultaneous request, then a full sweep.
        set_req(1, 5'd15, 32'hFFFEAAAA);
        req_valid = 4'b0010;
        clear_req = 1'b1;
        #1;
        chk("cq_ready", 32'(req_ready), 32'd0);
        chk("cq_gid", 32'(grant_id), 32'd0);
        tick();
        clear_req = 1'b0;
        req_valid = '0;
        chk("cq_we", 32'(gpr_write_enable), 32'd0);
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("clr1_we", 32'(gpr_write_enable), 32'd1);
            chk("clr1_addr", 32'(gpr_addrC), 32'(i));
            if (i == 3) begin
                req_valid = 4'hF;
                #1;
                chk("clr1_ready", 32'(req_ready), 32'd0);
                chk("clr1_init", 32'(init_done), 32'd0);
                req_valid = '0;
            end
        end
        tick();
        chk("clr1_done_init", 32'(init_done), 32'd1);
        chk("clr1_done_we", 32'(gpr_write_enable), 32'd0);
        addr_a = 5'd15;
        addr_b = 5'd5;
        #1;
        chk("clr1_rd15", data_out_A, 32'd0);
        chk("clr1_rd5", data_out_B, 32'd0);

        // Reset in the middle of a clear (counter at 10) restarts the sweep.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("clr2_addr", 32'(gpr_addrC), 32'(j));
        end
        rst_n = 1'b0;
        tick();
        chk("mid_rst_we", 32'(gpr_write_enable), 32'd0);
        chk("mid_rst_addr", 32'(gpr_addrC), 32'd0);
        chk("mid_rst_init", 32'(init_done), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("clr3_we", 32'(gpr_write_enable), 32'd1);
            chk("clr3_addr", 32'(gpr_addrC), 32'(i));
        end
        tick();
        chk("clr3_done_init", 32'(init_done), 32'd1);

        // Fairness and address collision: requester 0 streams, 3 joins.
        set_req(0, 5'd9, 32'h11);
        req_valid = 4'b0001;
        #1;
        chk("fair_a_ready", 32'(req_ready), 32'h1);
        tick();
        chk("fair_a_data", gpr_data_in_C, 32'h11);
        set_req(3, 5'd9, 32'h33);
        req_valid = 4'b1001;
        #1;
        chk("fair_b_ready", 32'(req_ready), 32'h8);
        chk("fair_b_gid", 32'(grant_id), 32'd3);
        tick();
        chk("fair_b_addr", 32'(gpr_addrC), 32'd9);
        chk("fair_b_data", gpr_data_in_C, 32'h33);
        req_valid = 4'b0001;
        #1;
        chk("fair_c_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        addr_a = 5'd9;
        #1;
        chk("coll_rd_b", data_out_A, 32'h33);
        tick();
        chk("coll_rd_c", data_out_A, 32'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
